// File: rtl/clock_mode_controller_pkg.sv
// clock_mode_controller_pkg: shared states, field limits and wrap helpers for the clock controller.
package clock_mode_controller_pkg;
  localparam int HR_W    = 5;
  localparam int MIN_W   = 6;
  localparam int HR_MAX  = 24;
  localparam int MIN_MAX = 60;
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    ALM_HR  = 3'd3,
    ALM_MIN = 3'd4
  } state_e;
  function automatic state_e next_state(input state_e s);
    return (s == ALM_MIN) ? RUN : state_e'(s + 3'd1);
  endfunction
  function automatic logic [HR_W-1:0] inc_hr(input logic [HR_W-1:0] v);
    return (v == HR_W'(HR_MAX - 1)) ? '0 : v + HR_W'(1);
  endfunction
  function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] v);
    return (v == MIN_W'(MIN_MAX - 1)) ? '0 : v + MIN_W'(1);
  endfunction
endpackage

// File: rtl/clock_mode_controller_tick_prescaler.sv
// tick_prescaler: modulo-DIV counter; tick_o is high during the cycle the count sits at DIV-1.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  always_comb begin
    cnt_d  = (!en_i || cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
    tick_d = en_i && (cnt_q == CW'(DIV - 2));
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end
  assign tick_o = tick_q;
endmodule

// File: rtl/clock_mode_controller.sv
// clock_mode_controller: mode FSM, time/alarm editing, counter load and alarm ring for the hh:mm:ss counter.
module clock_mode_controller
  import clock_mode_controller_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int RING_TICKS = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             mode_btn_i,
  input  logic             inc_btn_i,
  input  logic [HR_W-1:0]  cur_hr_i,
  input  logic [MIN_W-1:0] cur_min_i,
  input  logic [MIN_W-1:0] cur_sec_i,
  output logic             tick_o,
  output logic             load_o,
  output logic [HR_W-1:0]  load_hr_o,
  output logic [MIN_W-1:0] load_min_o,
  output logic [HR_W-1:0]  disp_hr_o,
  output logic [MIN_W-1:0] disp_min_o,
  output logic [2:0]       mode_o,
  output logic             alarm_en_o,
  output logic             alarm_ring_o
);
  localparam int RW = (RING_TICKS > 1) ? $clog2(RING_TICKS) : 1;
  state_e           state_q, state_d;
  logic [HR_W-1:0]  edit_hr_q, edit_hr_d, alm_hr_q, alm_hr_d, load_hr_q, load_hr_d;
  logic [MIN_W-1:0] edit_min_q, edit_min_d, alm_min_q, alm_min_d, load_min_q, load_min_d;
  logic             alarm_en_q, alarm_en_d, ring_q, ring_d, load_q, load_d;
  logic [RW-1:0]    ring_cnt_q, ring_cnt_d;
  logic             mode_p, inc_p, run_en, match, ring_end, tick;
  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .en_i   (run_en),
    .tick_o (tick)
  );
  always_comb begin
    // while ringing, any button press only silences the alarm
    mode_p     = mode_btn_i && !ring_q;
    inc_p      = inc_btn_i && !mode_btn_i && !ring_q;
    state_d    = mode_p ? next_state(state_q) : state_q;
    run_en     = (state_q == RUN) && (state_d == RUN);
    edit_hr_d  = (mode_p && state_q == RUN) ? cur_hr_i :
                 (inc_p && state_q == SET_HR) ? inc_hr(edit_hr_q) : edit_hr_q;
    edit_min_d = (mode_p && state_q == RUN) ? cur_min_i :
                 (inc_p && state_q == SET_MIN) ? inc_min(edit_min_q) : edit_min_q;
    alm_hr_d   = (inc_p && state_q == ALM_HR) ? inc_hr(alm_hr_q) : alm_hr_q;
    alm_min_d  = (inc_p && state_q == ALM_MIN) ? inc_min(alm_min_q) : alm_min_q;
    alarm_en_d = (inc_p && state_q == RUN) ? !alarm_en_q : alarm_en_q;
    load_d     = mode_p && state_q == SET_MIN;
    load_hr_d  = load_d ? edit_hr_q : load_hr_q;
    load_min_d = load_d ? edit_min_q : load_min_q;
    match      = state_q == RUN && alarm_en_q && !mode_btn_i && !inc_btn_i &&
                 cur_hr_i == alm_hr_q && cur_min_i == alm_min_q && cur_sec_i == '0;
    ring_end   = mode_btn_i || inc_btn_i || !alarm_en_q || state_q != RUN ||
                 (tick && ring_cnt_q == RW'(RING_TICKS - 1));
    ring_d     = ring_q ? !ring_end : match;
    ring_cnt_d = !ring_q ? '0 : tick ? ring_cnt_q + RW'(1) : ring_cnt_q;
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= RUN;
      edit_hr_q  <= '0;
      edit_min_q <= '0;
      alm_hr_q   <= '0;
      alm_min_q  <= '0;
      load_hr_q  <= '0;
      load_min_q <= '0;
      load_q     <= 1'b0;
      alarm_en_q <= 1'b0;
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      edit_hr_q  <= edit_hr_d;
      edit_min_q <= edit_min_d;
      alm_hr_q   <= alm_hr_d;
      alm_min_q  <= alm_min_d;
      load_hr_q  <= load_hr_d;
      load_min_q <= load_min_d;
      load_q     <= load_d;
      alarm_en_q <= alarm_en_d;
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end
  always_comb begin
    disp_hr_o  = (state_q == RUN) ? cur_hr_i :
                 (state_q == SET_HR || state_q == SET_MIN) ? edit_hr_q : alm_hr_q;
    disp_min_o = (state_q == RUN) ? cur_min_i :
                 (state_q == SET_HR || state_q == SET_MIN) ? edit_min_q : alm_min_q;
  end
  assign tick_o       = tick;
  assign load_o       = load_q;
  assign load_hr_o    = load_hr_q;
  assign load_min_o   = load_min_q;
  assign mode_o       = state_q;
  assign alarm_en_o   = alarm_en_q;
  assign alarm_ring_o = ring_q;
endmodule
